// File: rtl/rv_pkg.sv
// Shared RV32 definitions: opcode constants, NOP, default reset PC,
// fetch FSM encodings and a helper that slices the decode fields.
package rv_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef struct packed {
    logic [6:0] op;
    logic [2:0] func3;
  } instr_fields_t;

  function automatic instr_fields_t rv_fields(input logic [31:0] instr);
    instr_fields_t f;
    f.op    = instr[6:0];
    f.func3 = instr[14:12];
    return f;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small first-word-fall-through FIFO holding {pc, instr} entries between
// the memory response port and decode. clr wins over same-cycle push/pop.
module if_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full, push_en, pop_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  // A push into a full FIFO is only accepted when a pop frees a slot the same cycle.
  assign push_en   = push & ~clr & (~full | pop);
  assign pop_en    = pop & ~clr & ~empty;
  assign head_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CW'(push_en) - CW'(pop_en);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        mem_reg[gi] <= '0;
      end else if (push_en && (wr_ptr_reg == PW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !clr && full && !pop));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order fetches,
// buffers responses and hands {pc, instr} to decode; redirects flush and drain.
module if_stage
  import rv_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RV_RESET_PC),
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                id_ready,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [6:0]          instruct_op,
  output logic [2:0]          instruct_func3
);

  localparam int            CW      = $clog2(FIFO_DEPTH + 1);
  localparam int            EW      = 32 + PC_WIDTH;
  localparam logic [CW:0]   CREDITS = (CW + 1)'(FIFO_DEPTH);

  logic [1:0]          state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PC_WIDTH-1:0] tag_pc_reg, tag_pc_next;
  logic [PC_WIDTH-1:0] redirect_aligned;
  logic [CW-1:0]       outst_reg, outst_next;
  logic [CW-1:0]       drop_cnt_reg, drop_cnt_next;
  logic                req_fire, fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]       fifo_cnt;
  logic [EW-1:0]       fifo_head;
  instr_fields_t       fields;

  assign redirect_aligned = redirect_pc & ~PC_WIDTH'(3);

  // In-flight plus buffered words never exceed the FIFO size, so every
  // accepted response always has a slot waiting for it.
  assign imem_req_valid = (state_reg == ST_FETCH) && !redirect_valid &&
                          (({1'b0, outst_reg} + {1'b0, fifo_cnt}) < CREDITS);
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign fifo_push = imem_rsp_valid && (drop_cnt_reg == '0) && !redirect_valid;
  assign if_valid  = !fifo_empty && !redirect_valid;
  assign fifo_pop  = if_valid & id_ready;

  assign if_instr       = fifo_head[31:0];
  assign if_pc          = fifo_head[EW-1:32];
  assign fields         = rv_fields(if_instr);
  assign instruct_op    = fields.op;
  assign instruct_func3 = fields.func3;

  assign outst_next = outst_reg + CW'(req_fire) - CW'(imem_rsp_valid);

  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    pc_next       = pc_reg;
    tag_pc_next   = tag_pc_reg;
    state_next    = state_reg;

    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      drop_cnt_next = outst_next;
      pc_next       = redirect_aligned;
      tag_pc_next   = redirect_aligned;
    end else begin
      if (imem_rsp_valid && (drop_cnt_reg != '0)) drop_cnt_next = drop_cnt_reg - CW'(1);
      if (req_fire)  pc_next     = pc_reg + PC_WIDTH'(4);
      if (fifo_push) tag_pc_next = tag_pc_reg + PC_WIDTH'(4);
    end

    if (state_reg == ST_BOOT) state_next = ST_FETCH;
    else                      state_next = (drop_cnt_next != '0) ? ST_DRAIN : ST_FETCH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_BOOT;
      pc_reg       <= RESET_PC;
      tag_pc_reg   <= RESET_PC;
      outst_reg    <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      tag_pc_reg   <= tag_pc_next;
      outst_reg    <= outst_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  if_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({tag_pc_reg, imem_rsp_data}),
    .pop       (fifo_pop),
    .clr       (redirect_valid),
    .head_data (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  a_outst_no_underflow: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outst_reg != '0));
  a_drop_within_outst: assert property (@(posedge clk) disable iff (rst)
    drop_cnt_reg <= outst_reg);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory/decode model driven once per cycle,
// golden PC stream check on every pop, table of redirect vectors.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready, if_valid;
  logic [31:0] if_instr, if_pc;
  logic [6:0]  instruct_op;
  logic [2:0]  instruct_func3;

  always #5 clk = ~clk;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .instruct_op    (instruct_op),
    .instruct_func3 (instruct_func3)
  );

  typedef struct { logic [31:0] addr; int due; int ep; } mem_ent_t;
  typedef struct { logic [31:0] target; logic [31:0] exp_addr; int n_pops; } redir_vec_t;

  mem_ent_t   mem_q[$];
  redir_vec_t vecs[4];

  int checks, errors, cycle, epoch, buf_cnt, pops, n_req, last_due;
  int dly_min, dly_max, id_ready_pct;
  int first_fire, first_rsp, first_pop, boot_cycle;
  bit rand_ready, rst_ctl, redir_req;
  logic [31:0] redir_target, exp_pc, req_exp;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC3A5_7E13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One clock cycle: drive inputs at negedge, sample outputs 1 time unit later.
  task automatic step();
    bit          stale;
    int          d, due;
    logic [31:0] w;
    mem_ent_t    e;
    @(negedge clk);
    cycle++;
    rst            = rst_ctl;
    redirect_valid = redir_req;
    redirect_pc    = redir_target;
    if (redir_req) begin
      epoch++;
      exp_pc  = redir_target & 32'hFFFF_FFFC;
      req_exp = redir_target & 32'hFFFF_FFFC;
      buf_cnt = 0;
    end
    redir_req = 1'b0;
    stale = 1'b0;
    foreach (mem_q[i]) if (mem_q[i].ep != epoch) stale = 1'b1;
    if (!rst_ctl && mem_q.size() > 0 && mem_q[0].due <= cycle) begin
      e = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(e.addr);
      if (e.ep == epoch) begin
        buf_cnt++;
        if (first_rsp < 0) first_rsp = cycle;
      end
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    imem_req_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    id_ready       = ($urandom_range(1, 100) <= id_ready_pct);
    #1;
    if (!rst_ctl) begin
      if (stale) chk("drain_no_req", 32'(imem_req_valid), 32'h0);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, req_exp);
        d   = $urandom_range(dly_max, dly_min);
        due = cycle + d;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: imem_req_addr, due: due, ep: epoch});
        req_exp += 32'd4;
        n_req++;
        if (first_fire < 0) first_fire = cycle;
      end
      if (if_valid && id_ready) begin
        w = instr_of(exp_pc);
        $display("POP cyc=%0d pc=%08h instr=%08h op=%02h f3=%0d",
                 cycle, if_pc, if_instr, instruct_op, instruct_func3);
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, w);
        chk("fields", 32'({instruct_op, instruct_func3}), 32'({w[6:0], w[14:12]}));
        exp_pc += 32'd4;
        pops++;
        buf_cnt--;
        if (first_pop < 0) first_pop = cycle;
      end
    end
  endtask

  task automatic apply_reset(input bit chk_outputs);
    rst_ctl = 1'b1;
    mem_q.delete();
    redir_req = 1'b0; epoch = 0; buf_cnt = 0; n_req = 0; pops = 0;
    exp_pc = 32'h0; req_exp = 32'h0; last_due = 0;
    first_fire = -1; first_rsp = -1; first_pop = -1;
    dly_min = 1; dly_max = 1; rand_ready = 1'b0; id_ready_pct = 100;
    step();
    step();
    if (chk_outputs) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_fields", 32'({instruct_op, instruct_func3}), 32'h0);
    end
    rst_ctl = 1'b0;
    step();
    boot_cycle = cycle;
    if (chk_outputs) chk("boot_no_req", 32'(imem_req_valid), 32'h0);
  endtask

  task automatic run_pops(input int n, input int budget, input string name);
    int start = pops;
    int k = 0;
    while (pops < start + n && k < budget) begin
      step();
      k++;
    end
    chk({name, "_pops"}, 32'(pops - start), 32'(n));
  endtask

  task automatic wait_req(input int n, input int budget, input string name);
    int k = 0;
    while (n_req < n && k < budget) begin
      step();
      k++;
    end
    chk({name, "_reqs"}, 32'(n_req), 32'(n));
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redir_req    = 1'b1;
    redir_target = target;
    step();
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    redir_target = 32'h0;

    vecs[0] = '{target: 32'h0000_0103, exp_addr: 32'h0000_0100, n_pops: 3};
    vecs[1] = '{target: 32'h0000_0200, exp_addr: 32'h0000_0200, n_pops: 3};
    vecs[2] = '{target: 32'h0000_0002, exp_addr: 32'h0000_0000, n_pops: 3};
    vecs[3] = '{target: 32'hFFFF_FFFA, exp_addr: 32'hFFFF_FFF8, n_pops: 4};

    // Reset values, then a straight stream from 0x0 with a 1-cycle memory.
    apply_reset(1'b1);
    run_pops(8, 100, "t1_stream");
    chk("t1_first_req_cycle", 32'(first_fire - boot_cycle), 32'd1);
    chk("t1_rsp_to_valid", 32'(first_pop - first_rsp), 32'd1);

    // Decode stalls: requests stop once two words are in flight or buffered.
    id_ready_pct = 0;
    repeat (10) step();
    chk("t2_req_stalled", 32'(imem_req_valid), 32'h0);
    chk("t2_inflight_plus_buf", 32'(n_req - pops), 32'd2);
    chk("t2_if_valid", 32'(if_valid), 32'h1);
    id_ready_pct = 100;
    run_pops(6, 100, "t2_resume");

    // Redirect with two requests in flight: both responses are dropped.
    apply_reset(1'b0);
    dly_min = 3; dly_max = 3;
    wait_req(2, 20, "t3");
    redirect_to(32'h0000_0100);
    step();
    chk("t3_drain_req_valid", 32'(imem_req_valid), 32'h0);
    run_pops(4, 100, "t3_after");

    // Redirect vectors, each landing while the FIFO holds a word and decode pops.
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      while (buf_cnt == 0 && k < 50) begin
        step();
        k++;
      end
      chk("t4_buffered", 32'(buf_cnt > 0), 32'h1);
      redirect_to(vecs[i].target);
      chk("t4_pop_ignored", 32'(if_valid), 32'h0);
      step();
      chk("t4_fifo_empty", 32'(if_valid), 32'h0);
      chk("t4_req_addr", imem_req_addr, vecs[i].exp_addr);
      run_pops(vecs[i].n_pops, 100, "t4_stream");
    end

    // Random memory backpressure and latency, random decode stalls.
    apply_reset(1'b0);
    rand_ready = 1'b1; dly_min = 1; dly_max = 3; id_ready_pct = 70;
    run_pops(40, 2000, "t5_random");

    // Second redirect while still draining the first.
    apply_reset(1'b0);
    dly_min = 3; dly_max = 3;
    wait_req(2, 20, "t6");
    redirect_to(32'h0000_0040);
    redirect_to(32'h0000_0080);
    step();
    chk("t6_req_addr", imem_req_addr, 32'h0000_0080);
    run_pops(4, 100, "t6_stream");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
